status_reporter: RTL and testbench



---
 rtl/status_reporter.sv | 189 ++++++++++++++++++
 tb/tb_status_reporter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/status_reporter.sv
// rtl/status_reporter.sv - debounced input status reporter with ack handshake, heartbeat and boot report; optional STATUS_EDGE_FLAGS_EN adds a changed-bit mask
module status_reporter #(
    parameter int              N_IN             = 6,
    parameter int              DEBOUNCE_CYCLES  = 50000,
    parameter int              HEARTBEAT_CYCLES = 5000000,
    parameter logic [3:0]      CTRL_CODE        = 4'b0001,
    parameter logic [N_IN-1:0] ACTIVE_LOW_MASK  = {N_IN{1'b1}}
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_IN-1:0] in_raw,
    output logic [3:0]      out_ctrl,
    output logic [23:0]     out_data,
    output logic            out_wr,
    input  logic            out_ack,
    output logic [N_IN-1:0] status
);

    localparam int              DB_W    = $clog2(DEBOUNCE_CYCLES);
    localparam int              HB_W    = $clog2(HEARTBEAT_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HB_W-1:0] HB_LAST = HB_W'(HEARTBEAT_CYCLES - 1);

    typedef enum logic [0:0] {
        ST_IDLE,
        ST_SEND
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              launch;
    logic              done;

    logic [N_IN-1:0]   sync_q1;
    logic [N_IN-1:0]   sync_q2;
    logic [N_IN-1:0]   synced;

    logic [DB_W-1:0]   db_cnt     [N_IN];
    logic [DB_W-1:0]   db_cnt_nxt [N_IN];
    logic [N_IN-1:0]   status_nxt;

    logic [HB_W-1:0]   hb_cnt;
    logic              hb_expire;
    logic              hb_pending;
    logic              boot_pending;

    logic [N_IN-1:0]   reported;
    logic              change_pending;
    logic [23:0]       report_word;

    assign out_ctrl       = CTRL_CODE;
    assign synced         = sync_q2 ^ ACTIVE_LOW_MASK;
    assign change_pending = (status != reported);
    assign hb_expire      = (hb_cnt == HB_LAST);

    // Two-flop synchroniser; reset to the idle (inactive) level so the debouncer sees no activity out of reset
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q1 <= ACTIVE_LOW_MASK;
            sync_q2 <= ACTIVE_LOW_MASK;
        end else begin
            sync_q1 <= in_raw;
            sync_q2 <= sync_q1;
        end
    end

    // Per-bit debounce: count consecutive mismatching cycles, accept the new level on the last one
    always_comb begin
        status_nxt = status;
        for (int i = 0; i < N_IN; i++) begin
            db_cnt_nxt[i] = '0;
            if (synced[i] != status[i]) begin
                if (db_cnt[i] == DB_LAST) begin
                    status_nxt[i] = synced[i];
                end else begin
                    db_cnt_nxt[i] = db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Debounced state and counters
    always_ff @(posedge clk) begin
        if (rst) begin
            status <= '0;
            for (int i = 0; i < N_IN; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            status <= status_nxt;
            for (int i = 0; i < N_IN; i++) begin
                db_cnt[i] <= db_cnt_nxt[i];
            end
        end
    end

    // Heartbeat timer and pending flags; a launch consumes every pending reason and restarts the period
    always_ff @(posedge clk) begin
        if (rst) begin
            hb_cnt       <= '0;
            hb_pending   <= 1'b0;
            boot_pending <= 1'b1;
        end else if (launch) begin
            hb_cnt       <= '0;
            hb_pending   <= 1'b0;
            boot_pending <= 1'b0;
        end else if (hb_expire) begin
            hb_cnt       <= '0;
            hb_pending   <= 1'b1;
        end else begin
            hb_cnt       <= hb_cnt + 1'b1;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state: launch from IDLE on any pending reason, return on ack (out_wr is high throughout SEND)
    always_comb begin
        state_nxt = state;
        launch    = 1'b0;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (boot_pending || hb_pending || change_pending) begin
                    launch    = 1'b1;
                    state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                if (out_ack) begin
                    done      = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

`ifdef STATUS_EDGE_FLAGS_EN
    logic [N_IN-1:0] chg_acc;

    if (N_IN > 12) begin : g_width_check
        $error("status_reporter: N_IN must be <= 12 when STATUS_EDGE_FLAGS_EN is defined");
    end

    // Changed mask: toggles since the previous launch; toggles on the launch edge belong to the next word
    always_ff @(posedge clk) begin
        if (rst) begin
            chg_acc <= '0;
        end else if (launch) begin
            chg_acc <= status_nxt ^ status;
        end else begin
            chg_acc <= chg_acc | (status_nxt ^ status);
        end
    end
`endif

    // Report word: status in the low bits, optional changed mask above it, zeros elsewhere
    always_comb begin
        report_word              = '0;
        report_word[N_IN-1:0]    = status;
`ifdef STATUS_EDGE_FLAGS_EN
        report_word[2*N_IN-1:N_IN] = chg_acc;
`endif
    end

    // Outbound word register: captured on launch, held until the ack drops out_wr
    always_ff @(posedge clk) begin
        if (rst) begin
            out_wr   <= 1'b0;
            out_data <= '0;
            reported <= '0;
        end else if (launch) begin
            out_wr   <= 1'b1;
            out_data <= report_word;
            reported <= status;
        end else if (done) begin
            out_wr   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_status_reporter.sv
// tb/tb_status_reporter.sv - directed table-driven bench for status_reporter
module tb_status_reporter;

`ifdef STATUS_EDGE_FLAGS_EN
    localparam bit EF = 1'b1;
`else
    localparam bit EF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  in_raw;
    logic [3:0]  out_ctrl;
    logic [23:0] out_data;
    logic        out_wr;
    logic        out_ack;
    logic [5:0]  status;

    int   checks    = 0;
    int   errors    = 0;
    int   cyc       = 0;
    int   words     = 0;
    int   last_rise = 0;
    logic prev_wr   = 1'b0;

    typedef struct {
        logic [5:0]  in_val;
        int          n;
        logic [5:0]  st;
        logic        wr;
        logic [23:0] data;
    } vec_t;

    vec_t tbl [10];

    status_reporter #(
        .N_IN             (6),
        .DEBOUNCE_CYCLES  (4),
        .HEARTBEAT_CYCLES (100),
        .CTRL_CODE        (4'b0001),
        .ACTIVE_LOW_MASK  (6'h3F)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_raw   (in_raw),
        .out_ctrl (out_ctrl),
        .out_data (out_data),
        .out_wr   (out_wr),
        .out_ack  (out_ack),
        .status   (status)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (out_wr && !prev_wr) last_rise = cyc;
        if (out_wr && out_ack) words = words + 1;
        prev_wr = out_wr;
    end

    function automatic logic [23:0] mk(input logic [5:0] st, input logic [5:0] m);
        mk = {12'b0, (EF ? m : 6'b0), st};
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_rise(input int budget, output int t);
        t = -1;
        for (int i = 0; i < budget; i++) begin
            step(1);
            if (out_wr) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) begin
            checks++;
            errors++;
            $display("FAIL wait_rise: no out_wr within %0d cycles", budget);
        end
    endtask

    initial begin
        int t;
        int t_boot;
        int t_chg;
        int w0;
        int bad;

        tbl[0] = '{6'h3E, 5, 6'h00, 1'b0, mk(6'h00, 6'h00)};
        tbl[1] = '{6'h3E, 1, 6'h01, 1'b0, mk(6'h00, 6'h00)};
        tbl[2] = '{6'h3E, 1, 6'h01, 1'b1, mk(6'h01, 6'h01)};
        tbl[3] = '{6'h3E, 1, 6'h01, 1'b0, mk(6'h01, 6'h01)};
        tbl[4] = '{6'h3A, 3, 6'h01, 1'b0, mk(6'h01, 6'h01)};
        tbl[5] = '{6'h3E, 10, 6'h01, 1'b0, mk(6'h01, 6'h01)};
        tbl[6] = '{6'h3F, 5, 6'h01, 1'b0, mk(6'h01, 6'h01)};
        tbl[7] = '{6'h3F, 1, 6'h00, 1'b0, mk(6'h01, 6'h01)};
        tbl[8] = '{6'h3F, 1, 6'h00, 1'b1, mk(6'h00, 6'h01)};
        tbl[9] = '{6'h3F, 1, 6'h00, 1'b0, mk(6'h00, 6'h01)};

        rst     = 1'b1;
        in_raw  = 6'h3F;
        out_ack = 1'b1;
        step(3);
        chk("reset_wr", 32'(out_wr), 32'd0);
        chk("reset_data", 32'(out_data), 32'd0);
        chk("reset_status", 32'(status), 32'd0);
        chk("ctrl_code", 32'(out_ctrl), 32'd1);

        rst = 1'b0;
        step(1);
        chk("boot_wr", 32'(out_wr), 32'd1);
        chk("boot_data", 32'(out_data), 32'd0);
        t_boot = cyc;
        step(2);
        chk("boot_drop", 32'(out_wr), 32'd0);

        wait_rise(200, t);
        chk("hb1_gap", 32'(t - t_boot), 32'd101);
        chk("hb1_data", 32'(out_data), 32'd0);
        step(2);

        for (int i = 0; i < 10; i++) begin
            in_raw = tbl[i].in_val;
            step(tbl[i].n);
            chk($sformatf("vec%0d_status", i), 32'(status), 32'(tbl[i].st));
            chk($sformatf("vec%0d_wr", i), 32'(out_wr), 32'(tbl[i].wr));
            chk($sformatf("vec%0d_data", i), 32'(out_data), 32'(tbl[i].data));
        end

        t_chg = last_rise;
        wait_rise(200, t);
        chk("hb_restart_gap", 32'(t - t_chg), 32'd101);
        chk("hb2_data", 32'(out_data), 32'(mk(6'h00, 6'h00)));

        out_ack = 1'b0;
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            if (i == 20) in_raw = 6'h1F;
            step(1);
            if (out_wr !== 1'b1 || out_data !== mk(6'h00, 6'h00)) bad++;
        end
        chk("hold_frozen_cycles_bad", 32'(bad), 32'd0);
        chk("hold_status", 32'(status), 32'h20);
        out_ack = 1'b1;
        step(1);
        chk("hold_ack_drop", 32'(out_wr), 32'd0);
        step(1);
        chk("coalesced_wr", 32'(out_wr), 32'd1);
        chk("coalesced_data", 32'(out_data), 32'(mk(6'h20, 6'h20)));
        w0 = words;
        step(60);
        chk("coalesced_single_word", 32'(words - w0), 32'd1);

        out_ack = 1'b0;
        in_raw  = 6'h3F;
        wait_rise(20, t);
        chk("mid_send_data", 32'(out_data), 32'(mk(6'h00, 6'h20)));
        rst = 1'b1;
        step(1);
        chk("rst_mid_send_wr", 32'(out_wr), 32'd0);
        chk("rst_mid_send_data", 32'(out_data), 32'd0);
        step(2);
        rst = 1'b0;
        step(1);
        chk("reboot_wr", 32'(out_wr), 32'd1);
        chk("reboot_data", 32'(out_data), 32'd0);
        t_boot = cyc;

        in_raw = 6'h3D;
        step(10);
        chk("pulse_status_set", 32'(status), 32'h02);
        in_raw = 6'h3F;
        step(10);
        chk("pulse_status_clr", 32'(status), 32'h00);
        chk("pulse_held_wr", 32'(out_wr), 32'd1);
        chk("pulse_held_data", 32'(out_data), 32'd0);
        out_ack = 1'b1;
        step(1);
        chk("pulse_ack_drop", 32'(out_wr), 32'd0);
        wait_rise(200, t);
        chk("pulse_next_gap", 32'(t - t_boot), 32'd101);
        chk("pulse_next_data", 32'(out_data), 32'(mk(6'h00, 6'h02)));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
